// File: rtl/layer_pass_sequencer_pkg.sv
// Shared types and widths for the layer pass sequencer: layer kind, FSM states,
// and the per-pass id bundle handed to the NoC loader and psum write-back.
package layer_pass_sequencer_pkg;

  localparam int M_WIDTH   = 10;
  localparam int C_WIDTH   = 10;
  localparam int N_WIDTH   = 3;
  localparam int n_WIDTH   = 3;
  localparam int p_WIDTH   = 5;
  localparam int q_WIDTH   = 3;
  localparam int r_WIDTH   = 2;
  localparam int t_WIDTH   = 3;
  localparam int MAX_SLOTS = 4;

  localparam int MSTEP_WIDTH = p_WIDTH + t_WIDTH;
  localparam int CSTEP_WIDTH = q_WIDTH + r_WIDTH;

  typedef enum logic {
    LAYER_CONV = 1'b0,
    LAYER_MAX  = 1'b1
  } layer_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_ADVANCE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [N_WIDTH-1:0]                ifmap_base;
    logic [MAX_SLOTS-1:0][M_WIDTH-1:0] filter_ids;
    logic [MAX_SLOTS-1:0]              filter_id_valid;
    logic [MAX_SLOTS-1:0][C_WIDTH-1:0] channel_ids;
    logic [MAX_SLOTS-1:0]              channel_id_valid;
    logic [M_WIDTH-1:0]                psum_channel_base;
    logic                              bias_sel;
    logic                              last_cgroup;
  } pass_ids_t;

endpackage

// File: rtl/pass_slot_gen.sv
// Per-slot id generation: id[i] = base + i*stride for the first `count` slots,
// valid only while below `limit`; slots beyond `count` (or when disabled) drive 0.
module pass_slot_gen #(
  parameter int ID_W     = 10,
  parameter int STRIDE_W = 5,
  parameter int CNT_W    = 3,
  parameter int SLOTS    = 4
) (
  input  logic                       enable,
  input  logic [ID_W:0]              base,
  input  logic [STRIDE_W-1:0]        stride,
  input  logic [CNT_W-1:0]           count,
  input  logic [ID_W-1:0]            limit,
  output logic [SLOTS-1:0][ID_W-1:0] ids,
  output logic [SLOTS-1:0]           valid
);

  // Two extra bits keep base + (SLOTS-1)*stride from wrapping before the limit compare.
  localparam int SUM_W = ID_W + 2;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic [SUM_W-1:0] id_full;
    logic             in_use;

    assign id_full  = SUM_W'(base) + SUM_W'(i) * SUM_W'(stride);
    assign in_use   = enable && (i < int'(count));
    assign ids[i]   = in_use ? id_full[ID_W-1:0] : '0;
    assign valid[i] = in_use && (id_full < SUM_W'(limit));
  end

endmodule

// File: rtl/layer_pass_sequencer.sv
// Walks the N/M/C pass loop nest of one layer and issues per-pass slot ids over valid/ready.
// First pass_valid two cycles after start; ids hold while stalled; abort returns to IDLE.
module layer_pass_sequencer
  import layer_pass_sequencer_pkg::*;
(
  input  logic                              core_clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              abort,
  input  layer_t                            cfg_X,
  input  logic [M_WIDTH-1:0]                cfg_M,
  input  logic [C_WIDTH-1:0]                cfg_C,
  input  logic [N_WIDTH-1:0]                cfg_N,
  input  logic [n_WIDTH-1:0]                cfg_n,
  input  logic [p_WIDTH-1:0]                cfg_p,
  input  logic [q_WIDTH-1:0]                cfg_q,
  input  logic [r_WIDTH-1:0]                cfg_r,
  input  logic [t_WIDTH-1:0]                cfg_t,
  output logic                              pass_valid,
  input  logic                              pass_ready,
  output logic [N_WIDTH-1:0]                ifmap_base,
  output logic [MAX_SLOTS-1:0][M_WIDTH-1:0] filter_ids,
  output logic [MAX_SLOTS-1:0]              filter_id_valid,
  output logic [MAX_SLOTS-1:0][C_WIDTH-1:0] channel_ids,
  output logic [MAX_SLOTS-1:0]              channel_id_valid,
  output logic [M_WIDTH-1:0]                psum_channel_base,
  output logic                              bias_sel,
  output logic                              last_cgroup,
  output logic                              busy,
  output logic                              done,
  output logic                              cfg_error
);

  state_t state, state_nxt;

  layer_t                 x_q;
  logic [M_WIDTH-1:0]     m_lim;
  logic [C_WIDTH-1:0]     c_lim;
  logic [N_WIDTH-1:0]     n_lim;
  logic [n_WIDTH-1:0]     n_step;
  logic [p_WIDTH-1:0]     p_q;
  logic [q_WIDTH-1:0]     q_q;
  logic [r_WIDTH-1:0]     r_q;
  logic [t_WIDTH-1:0]     t_q;
  logic [MSTEP_WIDTH-1:0] mstep;
  logic [CSTEP_WIDTH-1:0] cstep;
  logic                   err_q;

  logic [M_WIDTH:0] m0, m_sum;
  logic [C_WIDTH:0] c0, c_sum;
  logic [N_WIDTH:0] b0, b_sum;
  logic             c_wrap, m_wrap, b_wrap, last_pass, cfg_err, issuing, is_conv;

  logic [MAX_SLOTS-1:0][M_WIDTH-1:0] f_ids;
  logic [MAX_SLOTS-1:0][C_WIDTH-1:0] c_ids;
  logic [MAX_SLOTS-1:0]              f_vld, c_vld;
  pass_ids_t                         pass;

  // Pooling layers ignore the filter dimension, so only CONV checks M/p/t for zero.
  assign cfg_err = (cfg_C == '0) || (cfg_N == '0) || (cfg_n == '0) || (cfg_q == '0)
                || (cfg_r == '0) || (int'(cfg_t) > MAX_SLOTS) || (int'(cfg_r) > MAX_SLOTS)
                || ((cfg_X == LAYER_CONV) && ((cfg_M == '0) || (cfg_p == '0) || (cfg_t == '0)));

  assign c_sum     = c0 + (C_WIDTH+1)'(cstep);
  assign m_sum     = m0 + (M_WIDTH+1)'(mstep);
  assign b_sum     = b0 + (N_WIDTH+1)'(n_step);
  assign c_wrap    = c_sum >= {1'b0, c_lim};
  assign m_wrap    = (x_q == LAYER_MAX) || (m_sum >= {1'b0, m_lim});
  assign b_wrap    = b_sum >= {1'b0, n_lim};
  assign last_pass = c_wrap && m_wrap && b_wrap;

  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start) state_nxt = ST_LOAD;
        ST_LOAD:    state_nxt = cfg_err ? ST_DONE : ST_ISSUE;
        ST_ISSUE:   if (pass_ready) state_nxt = ST_ADVANCE;
        ST_ADVANCE: state_nxt = last_pass ? ST_DONE : ST_ISSUE;
        ST_DONE:    state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= LAYER_CONV; m_lim <= '0; c_lim <= '0; n_lim <= '0; n_step <= '0;
      p_q <= '0; q_q <= '0; r_q <= '0; t_q <= '0;
      mstep <= '0; cstep <= '0; err_q <= 1'b0;
      m0 <= '0; c0 <= '0; b0 <= '0;
    end else if (state == ST_LOAD) begin
      x_q <= cfg_X; m_lim <= cfg_M; c_lim <= cfg_C; n_lim <= cfg_N; n_step <= cfg_n;
      p_q <= cfg_p; q_q <= cfg_q; r_q <= cfg_r; t_q <= cfg_t;
      mstep <= MSTEP_WIDTH'(cfg_p) * MSTEP_WIDTH'(cfg_t);
      cstep <= CSTEP_WIDTH'(cfg_q) * CSTEP_WIDTH'(cfg_r);
      err_q <= cfg_err;
      m0 <= '0; c0 <= '0; b0 <= '0;
    end else if (state == ST_ADVANCE) begin
      if (!c_wrap) begin
        c0 <= c_sum;
      end else begin
        c0 <= '0;
        if (!m_wrap) begin
          m0 <= m_sum;
        end else begin
          m0 <= '0;
          b0 <= b_sum;
        end
      end
    end
  end

  assign issuing = (state == ST_ISSUE);
  assign is_conv = (x_q == LAYER_CONV);

  pass_slot_gen #(.ID_W(M_WIDTH), .STRIDE_W(p_WIDTH), .CNT_W(t_WIDTH), .SLOTS(MAX_SLOTS))
    u_filter_slots (.enable(issuing && is_conv), .base(m0), .stride(p_q), .count(t_q),
                    .limit(m_lim), .ids(f_ids), .valid(f_vld));

  pass_slot_gen #(.ID_W(C_WIDTH), .STRIDE_W(q_WIDTH), .CNT_W(r_WIDTH), .SLOTS(MAX_SLOTS))
    u_channel_slots (.enable(issuing), .base(c0), .stride(q_q), .count(r_q),
                     .limit(c_lim), .ids(c_ids), .valid(c_vld));

  always_comb begin
    pass       = '0;
    pass_valid = issuing;
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    cfg_error  = (state == ST_DONE) && err_q;
    if (issuing) begin
      pass.ifmap_base        = b0[N_WIDTH-1:0];
      pass.filter_ids        = f_ids;
      pass.filter_id_valid   = f_vld;
      pass.channel_ids       = c_ids;
      pass.channel_id_valid  = c_vld;
      pass.psum_channel_base = is_conv ? m0[M_WIDTH-1:0] : M_WIDTH'(c0[C_WIDTH-1:0]);
      pass.bias_sel          = is_conv && (c0 == '0);
      pass.last_cgroup       = !is_conv || c_wrap;
    end
  end

  assign ifmap_base        = pass.ifmap_base;
  assign filter_ids        = pass.filter_ids;
  assign filter_id_valid   = pass.filter_id_valid;
  assign channel_ids       = pass.channel_ids;
  assign channel_id_valid  = pass.channel_id_valid;
  assign psum_channel_base = pass.psum_channel_base;
  assign bias_sel          = pass.bias_sel;
  assign last_cgroup       = pass.last_cgroup;

endmodule

// File: tb/tb_layer_pass_sequencer.sv
// Randomized bench for layer_pass_sequencer against a loop-nest reference model.
module tb_layer_pass_sequencer;
  import layer_pass_sequencer_pkg::*;

  logic core_clk = 1'b0;
  logic reset_n = 1'b0, start = 1'b0, abort = 1'b0, pass_ready = 1'b0;
  layer_t cfg_X = LAYER_CONV;
  logic [M_WIDTH-1:0] cfg_M = '0;
  logic [C_WIDTH-1:0] cfg_C = '0;
  logic [N_WIDTH-1:0] cfg_N = '0;
  logic [n_WIDTH-1:0] cfg_n = '0;
  logic [p_WIDTH-1:0] cfg_p = '0;
  logic [q_WIDTH-1:0] cfg_q = '0;
  logic [r_WIDTH-1:0] cfg_r = '0;
  logic [t_WIDTH-1:0] cfg_t = '0;
  logic pass_valid, bias_sel, last_cgroup, busy, done, cfg_error;
  logic [N_WIDTH-1:0] ifmap_base;
  logic [MAX_SLOTS-1:0][M_WIDTH-1:0] filter_ids;
  logic [MAX_SLOTS-1:0][C_WIDTH-1:0] channel_ids;
  logic [MAX_SLOTS-1:0] filter_id_valid, channel_id_valid;
  logic [M_WIDTH-1:0] psum_channel_base;

  layer_pass_sequencer dut (
    .core_clk(core_clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_X(cfg_X), .cfg_M(cfg_M), .cfg_C(cfg_C), .cfg_N(cfg_N), .cfg_n(cfg_n),
    .cfg_p(cfg_p), .cfg_q(cfg_q), .cfg_r(cfg_r), .cfg_t(cfg_t),
    .pass_valid(pass_valid), .pass_ready(pass_ready), .ifmap_base(ifmap_base),
    .filter_ids(filter_ids), .filter_id_valid(filter_id_valid),
    .channel_ids(channel_ids), .channel_id_valid(channel_id_valid),
    .psum_channel_base(psum_channel_base), .bias_sel(bias_sel),
    .last_cgroup(last_cgroup), .busy(busy), .done(done), .cfg_error(cfg_error)
  );

  always #5 core_clk = ~core_clk;

  int n_checks = 0, n_errors = 0;
  int im, ic, i_N, i_n, ip, iq, ir, it, ix;
  pass_ids_t exp_q[$];
  pass_ids_t got_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pass_ids_t cur_pass();
    pass_ids_t s;
    s.ifmap_base = ifmap_base; s.filter_ids = filter_ids; s.filter_id_valid = filter_id_valid;
    s.channel_ids = channel_ids; s.channel_id_valid = channel_id_valid;
    s.psum_channel_base = psum_channel_base; s.bias_sel = bias_sel; s.last_cgroup = last_cgroup;
    return s;
  endfunction

  function automatic bit model_err();
    return (ic == 0) || (i_N == 0) || (i_n == 0) || (iq == 0) || (ir == 0) || (it > 4) || (ir > 4)
        || ((ix == 0) && ((im == 0) || (ip == 0) || (it == 0)));
  endfunction

  // Reference: enumerate the loop nest directly, batch outermost, channel innermost.
  task automatic build_model();
    int mstep, cstep, mlim;
    exp_q.delete();
    if (model_err()) return;
    mstep = (ix != 0) ? 1 : ip * it;
    cstep = iq * ir;
    mlim  = (ix != 0) ? 1 : im;
    for (int b = 0; b < i_N; b += i_n)
      for (int m = 0; m < mlim; m += mstep)
        for (int c = 0; c < ic; c += cstep) begin
          pass_ids_t e = '0;
          e.ifmap_base = b[N_WIDTH-1:0];
          for (int i = 0; i < 4; i++) begin
            if (ix == 0 && i < it) begin
              e.filter_ids[i] = M_WIDTH'(m + i * ip);
              e.filter_id_valid[i] = (m + i * ip) < im;
            end
            if (i < ir) begin
              e.channel_ids[i] = C_WIDTH'(c + i * iq);
              e.channel_id_valid[i] = (c + i * iq) < ic;
            end
          end
          e.psum_channel_base = M_WIDTH'((ix != 0) ? c : m);
          e.bias_sel = (ix == 0) && (c == 0);
          e.last_cgroup = (ix != 0) || (c + cstep >= ic);
          exp_q.push_back(e);
        end
  endtask

  task automatic drive_cfg();
    cfg_X = (ix != 0) ? LAYER_MAX : LAYER_CONV;
    cfg_M = M_WIDTH'(im); cfg_C = C_WIDTH'(ic); cfg_N = N_WIDTH'(i_N); cfg_n = n_WIDTH'(i_n);
    cfg_p = p_WIDTH'(ip); cfg_q = q_WIDTH'(iq); cfg_r = r_WIDTH'(ir); cfg_t = t_WIDTH'(it);
  endtask

  task automatic set_cfg(input int x, input int m, input int c, input int nn, input int n,
                         input int p, input int q, input int r, input int t);
    ix = x; im = m; ic = c; i_N = nn; i_n = n; ip = p; iq = q; ir = r; it = t;
  endtask

  task automatic run_layer(input int ready_pct, input int stall_at, input bit mid_start);
    int idx = 0, cyc = 1, stall = 0, first = -1, done_cyc = -1;
    bit err, finished = 0;
    pass_ids_t held = '0;
    err = model_err();
    build_model();
    got_q.delete();
    @(negedge core_clk); drive_cfg(); start = 1'b1;
    @(negedge core_clk); start = 1'b0;
    while (!finished && cyc < 20000) begin
      if (done) begin
        finished = 1; done_cyc = cyc;
        check("cfg_error", cfg_error, err);
        check("valid_at_done", pass_valid, 0);
      end else begin
        start = 1'b0;
        if (pass_valid) begin
          if (first < 0) first = cyc;
          if (idx < exp_q.size()) check("pass", cur_pass(), exp_q[idx]);
          else check("extra_pass", idx, exp_q.size() - 1);
          if (idx == stall_at && stall < 10) begin
            if (stall == 0) held = cur_pass();
            else check("stall_stable", cur_pass(), held);
            pass_ready = 1'b0; stall++;
          end else begin
            pass_ready = ($urandom_range(99) < ready_pct);
          end
          if (pass_ready) begin got_q.push_back(cur_pass()); idx++; end
          if (mid_start && idx == 2 && exp_q.size() > 5) begin
            cfg_M = M_WIDTH'($urandom); cfg_C = C_WIDTH'($urandom); cfg_t = t_WIDTH'($urandom);
            start = 1'b1;
          end
        end else begin
          pass_ready = 1'($urandom_range(1));
        end
        @(negedge core_clk); cyc++;
      end
    end
    start = 1'b0; pass_ready = 1'b0;
    check("timeout", finished, 1);
    check("pass_count", idx, exp_q.size());
    if (err) check("err_done_latency", done_cyc, 2);
    else     check("first_valid_latency", first, 2);
    @(negedge core_clk);
    check("done_one_cycle", {done, busy}, 2'b00);
  endtask

  initial begin
    #1 check("reset_outputs", {pass_valid, busy, done, cfg_error, ifmap_base, filter_ids,
           filter_id_valid, channel_ids, channel_id_valid, psum_channel_base, bias_sel,
           last_cgroup}, '0);
    repeat (2) @(negedge core_clk);
    reset_n = 1'b1;

    set_cfg(0, 192, 64, 1, 1, 16, 2, 1, 1);
    run_layer(100, -1, 0);
    check("conv2_count", got_q.size(), 384);
    if (got_q.size() == 384) begin
      check("conv2_p0", {got_q[0].filter_ids[0], got_q[0].channel_ids[0], got_q[0].bias_sel}, {10'd0, 10'd0, 1'b1});
      check("conv2_p32", {got_q[32].filter_ids[0], got_q[32].channel_ids[0]}, {10'd16, 10'd0});
      check("conv2_p31_last", got_q[31].last_cgroup, 1);
    end

    set_cfg(0, 64, 3, 1, 1, 16, 1, 1, 2);
    run_layer(70, -1, 0);
    check("conv1_count", got_q.size(), 6);
    if (got_q.size() == 6) begin
      check("conv1_p0", {got_q[0].filter_ids[1], got_q[0].filter_ids[0], got_q[0].filter_id_valid}, {10'd16, 10'd0, 4'b0011});
      check("conv1_p3", {got_q[3].filter_ids[1], got_q[3].filter_ids[0], got_q[3].channel_ids[0]}, {10'd48, 10'd32, 10'd0});
    end

    set_cfg(0, 40, 1, 1, 1, 16, 1, 1, 2);
    run_layer(100, -1, 0);
    if (got_q.size() >= 2)
      check("tail_p1", {got_q[1].filter_ids[1], got_q[1].filter_ids[0], got_q[1].filter_id_valid}, {10'd48, 10'd32, 4'b0001});

    set_cfg(1, 0, 64, 1, 1, 0, 1, 1, 0);
    run_layer(80, -1, 0);
    check("max1_count", got_q.size(), 64);
    foreach (got_q[k])
      check("max1_pass", {got_q[k].psum_channel_base, got_q[k].bias_sel, got_q[k].filter_id_valid},
            {10'(got_q[k].channel_ids[0]), 1'b0, 4'b0000});

    set_cfg(0, 64, 12, 2, 1, 8, 2, 2, 2);
    run_layer(100, 5, 1);

    set_cfg(0, 64, 3, 1, 1, 16, 1, 1, 5);
    run_layer(100, -1, 0);

    // Abort while a pass is being accepted: sequencer drops straight back to idle.
    set_cfg(0, 64, 3, 1, 1, 16, 1, 1, 2);
    @(negedge core_clk); drive_cfg(); start = 1'b1;
    @(negedge core_clk); start = 1'b0;
    @(negedge core_clk);
    check("abort_pre_valid", pass_valid, 1);
    pass_ready = 1'b1; abort = 1'b1;
    @(negedge core_clk); abort = 1'b0; pass_ready = 1'b0;
    check("abort_idle", {busy, pass_valid, done}, 3'b000);

    // Asynchronous reset in the middle of a layer.
    @(negedge core_clk); drive_cfg(); start = 1'b1;
    @(negedge core_clk); start = 1'b0; pass_ready = 1'b1;
    for (int k = 0; k < 40 && got_q.size() < 100; k++) begin
      if (pass_valid && k > 6) begin
        reset_n = 1'b0;
        break;
      end
      @(negedge core_clk);
    end
    #1 check("midlayer_reset", {pass_valid, busy, done, cfg_error, ifmap_base, filter_ids,
           filter_id_valid, channel_ids, channel_id_valid, psum_channel_base, bias_sel,
           last_cgroup}, '0);
    pass_ready = 1'b0;
    @(negedge core_clk); reset_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      set_cfg(($urandom_range(3) == 0) ? 1 : 0, $urandom_range(64, 1), $urandom_range(24, 1),
              $urandom_range(7, 1), $urandom_range(7, 1), $urandom_range(31, 4),
              $urandom_range(7, 2), $urandom_range(3, 1), $urandom_range(4, 1));
      run_layer(60, (k == 1) ? 3 : -1, k == 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
